sram_1r1w_sync: RTL and testbench

Parametrised single-clock, one-read/one-write storage array with registered read data, optional write-to-read bypass, per-lane write mask and a built-in sequential zero-initialisation engine. It generalises the fixed-size combinational-read tables (e.g. the 33x6 branch/next-pointer tables) so that wider, deeper or masked variants share one block. The block sits under predictor and queue metadata structures that need deterministic post-reset contents without relying on simulator X-state.

---
 rtl/sram_pkg.sv | 35 +++
 rtl/sram_1r1w_core.sv | 48 ++++
 rtl/sram_1r1w_sync.sv | 166 ++++++++++++++++
 tb/tb_sram_1r1w_sync.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the sram_1r1w_sync storage block.
//   sram_state_e : control FSM states (zero-initialisation vs normal operation)
//   SRAM_MAX_W   : widest data word the lane-expansion helper supports
//   expand_mask  : widens a per-lane write mask into a per-bit write mask
// No ports (package).
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    localparam int SRAM_MAX_W = 1024;

    // Each lane bit is replicated over its 'gran' data bits; bits beyond
    // gran*nlanes stay zero so callers can simply truncate to their WIDTH.
    function automatic logic [SRAM_MAX_W-1:0] expand_mask(
        input logic [SRAM_MAX_W-1:0] lane_mask,
        input int                    gran,
        input int                    nlanes
    );
        logic [SRAM_MAX_W-1:0] bit_mask;
        bit_mask = '0;
        for (int i = 0; i < SRAM_MAX_W; i++) begin
            if (i < gran * nlanes) begin
                bit_mask[i] = lane_mask[i / gran];
            end
        end
        return bit_mask;
    endfunction

endpackage : sram_pkg

// File: rtl/sram_1r1w_core.sv
// -----------------------------------------------------------------------------
// sram_1r1w_core
// Pure storage array: one synchronous bit-masked write port and one
// synchronous read port, no reset. Kept free of control logic so it can be
// replaced by a vendor SRAM macro with the same read-first behaviour.
//   clock      : single clock, rising edge
//   we_i       : write enable
//   waddr_i    : write address (caller guarantees < DEPTH)
//   wbmask_i   : per-bit write enable
//   wdata_i    : write data
//   re_i       : read enable; rdata_o holds when low
//   raddr_i    : read address (caller guarantees < DEPTH)
//   rdata_o    : registered read data (old contents on same-address write)
// -----------------------------------------------------------------------------
module sram_1r1w_core #(
    parameter int DEPTH  = 33,
    parameter int WIDTH  = 6,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wbmask_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto SRAM macros; contents are
    // made deterministic by the owner's zero-initialisation sweep instead.
    // NOTE: both updates are non-blocking, so a read of the address being
    // written in the same cycle returns the pre-write contents (read-first).
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= (mem_q[waddr_i] & ~wbmask_i) | (wdata_i & wbmask_i);
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : sram_1r1w_core

// File: rtl/sram_1r1w_sync.sv
// -----------------------------------------------------------------------------
// sram_1r1w_sync
// One-read/one-write storage array with registered read data, optional
// write-to-read bypass, per-lane write mask and a sequential zero-init engine
// that runs after reset and on flush.
//   clock    : single clock, rising edge
//   reset_n  : synchronous active-low reset; restarts zero-initialisation
//   flush    : pulse in READY re-zeroes the whole array (ignored during INIT)
//   ready    : registered; high when user reads/writes are accepted
//   R0_addr  : read address; R0_en read enable; R0_data registered read data
//   W0_addr  : write address; W0_en write enable
//   W0_mask  : per-lane write enable, lane i = bits [i*MASK_GRAN +: MASK_GRAN]
//   W0_data  : write data
// Addresses >= DEPTH: writes are dropped and reads return zero.
// -----------------------------------------------------------------------------
module sram_1r1w_sync
    import sram_pkg::*;
#(
    parameter int DEPTH     = 33,
    parameter int WIDTH     = 6,
    parameter int MASK_GRAN = WIDTH,
    parameter int BYPASS    = 1,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    output logic                         ready,
    input  logic [ADDR_W-1:0]            R0_addr,
    input  logic                         R0_en,
    output logic [WIDTH-1:0]             R0_data,
    input  logic [ADDR_W-1:0]            W0_addr,
    input  logic                         W0_en,
    input  logic [WIDTH/MASK_GRAN-1:0]   W0_mask,
    input  logic [WIDTH-1:0]             W0_data
);

    localparam int                NLANES    = WIDTH / MASK_GRAN;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    // ---------------------------------------------------------------- state
    sram_state_e       state_q,    state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              ready_q,    ready_d;
    // Read-output shaping, captured alongside each accepted read:
    //   rd_zero_q  forces zero (reset state, out-of-range read)
    //   byp_*_q    bits of the same-cycle write that override the old entry
    logic              rd_zero_q,  rd_zero_d;
    logic [WIDTH-1:0]  byp_mask_q, byp_mask_d;
    logic [WIDTH-1:0]  byp_data_q, byp_data_d;

    // ------------------------------------------------------ core interface
    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [WIDTH-1:0]  core_bmask;
    logic [WIDTH-1:0]  core_wdata;
    logic              core_re;
    logic [WIDTH-1:0]  core_rdata;

    // ------------------------------------------------------ decode helpers
    logic              r_in_range;
    logic              w_in_range;
    logic              user_wr;
    logic              bypass_hit;
    logic [WIDTH-1:0]  lane_bmask;

    assign r_in_range = {1'b0, R0_addr} < DEPTH_EXT;
    assign w_in_range = {1'b0, W0_addr} < DEPTH_EXT;
    assign lane_bmask = WIDTH'(expand_mask(SRAM_MAX_W'(W0_mask), MASK_GRAN, NLANES));

    // A flush cycle drops the user write but still serves the read.
    assign user_wr    = W0_en && w_in_range && !flush && (|W0_mask);
    assign bypass_hit = (BYPASS != 0) && user_wr && r_in_range && (R0_addr == W0_addr);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ready_d    = ready_q;
        rd_zero_d  = rd_zero_q;
        byp_mask_d = byp_mask_q;
        byp_data_d = byp_data_q;
        core_we    = 1'b0;
        core_waddr = W0_addr;
        core_bmask = lane_bmask;
        core_wdata = W0_data;
        core_re    = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                // Sweep one entry per cycle with zeros; user ports ignored.
                core_we    = 1'b1;
                core_waddr = init_cnt_q;
                core_bmask = '1;
                core_wdata = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_IDX) begin
                    state_d    = ST_READY;
                    ready_d    = 1'b1;
                    init_cnt_d = '0;
                end
            end
            ST_READY: begin
                core_we = user_wr;
                core_re = R0_en && r_in_range;
                if (R0_en) begin
                    rd_zero_d  = !r_in_range;
                    byp_mask_d = bypass_hit ? lane_bmask : '0;
                    byp_data_d = W0_data;
                end
                if (flush) begin
                    state_d    = ST_INIT;
                    ready_d    = 1'b0;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            rd_zero_q  <= 1'b1;
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
            rd_zero_q  <= rd_zero_d;
            byp_mask_q <= byp_mask_d;
            byp_data_q <= byp_data_d;
        end
    end

    // ----------------------------------------------------------- storage
    // Core ports are quiet while reset is held so no stray access happens.
    sram_1r1w_core #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clock    (clock),
        .we_i     (core_we && reset_n),
        .waddr_i  (core_waddr),
        .wbmask_i (core_bmask),
        .wdata_i  (core_wdata),
        .re_i     (core_re && reset_n),
        .raddr_i  (R0_addr),
        .rdata_o  (core_rdata)
    );

    // ------------------------------------------------------------ outputs
    // Built only from flops: core read register plus captured shaping state.
    assign R0_data = rd_zero_q ? '0
                               : ((core_rdata & ~byp_mask_q) | (byp_data_q & byp_mask_q));
    assign ready   = ready_q;

endmodule : sram_1r1w_sync

// File: tb/tb_sram_1r1w_sync.sv
// -----------------------------------------------------------------------------
// tb_sram_1r1w_sync
// Directed bench for sram_1r1w_sync. Three instances share clock, reset and
// flush: default (33x6, write-first), read-first twin driven with the same
// stimulus, and a 33x16 instance with two byte lanes.
// -----------------------------------------------------------------------------
module tb_sram_1r1w_sync;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n = 1'b0;
    logic flush   = 1'b0;

    // default-width stimulus shared by dut and dut_nb
    logic       r_en = 1'b0;
    logic [5:0] r_addr = '0;
    logic       w_en = 1'b0;
    logic [5:0] w_addr = '0;
    logic [0:0] w_mask = 1'b1;
    logic [5:0] w_data = '0;
    logic [5:0] rdata, rdata_nb;
    logic       ready, ready_nb;

    // 16-bit masked instance stimulus
    logic        m_r_en = 1'b0;
    logic [5:0]  m_r_addr = '0;
    logic        m_w_en = 1'b0;
    logic [5:0]  m_w_addr = '0;
    logic [1:0]  m_w_mask = '0;
    logic [15:0] m_w_data = '0;
    logic [15:0] m_rdata;
    logic        m_ready;

    sram_1r1w_sync dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .ready(ready),
        .R0_addr(r_addr), .R0_en(r_en), .R0_data(rdata),
        .W0_addr(w_addr), .W0_en(w_en), .W0_mask(w_mask), .W0_data(w_data)
    );

    sram_1r1w_sync #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .flush(flush), .ready(ready_nb),
        .R0_addr(r_addr), .R0_en(r_en), .R0_data(rdata_nb),
        .W0_addr(w_addr), .W0_en(w_en), .W0_mask(w_mask), .W0_data(w_data)
    );

    sram_1r1w_sync #(.WIDTH(16), .MASK_GRAN(8)) dut_m (
        .clock(clock), .reset_n(reset_n), .flush(flush), .ready(m_ready),
        .R0_addr(m_r_addr), .R0_en(m_r_en), .R0_data(m_rdata),
        .W0_addr(m_w_addr), .W0_en(m_w_en), .W0_mask(m_w_mask), .W0_data(m_w_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] model [33];

    typedef struct {
        string      name;
        logic       r_en;
        logic [5:0] r_addr;
        logic       w_en;
        logic [5:0] w_addr;
        logic       w_mask;
        logic [5:0] w_data;
        logic       chk;
        logic [5:0] exp;
        logic [5:0] exp_nb;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic re, input int ra,
                                input logic we, input int wa, input logic wm,
                                input int wd, input logic c, input int e, input int enb);
        vec_t v;
        v.name = n;    v.r_en = re;        v.r_addr = ra[5:0];
        v.w_en = we;   v.w_addr = wa[5:0]; v.w_mask = wm;
        v.w_data = wd[5:0];
        v.chk = c;     v.exp = e[5:0];     v.exp_nb = enb[5:0];
        return v;
    endfunction

    task automatic idle_inputs();
        r_en = 1'b0; w_en = 1'b0; w_mask = 1'b1; flush = 1'b0;
    endtask

    task automatic clear_model();
        for (int a = 0; a < 33; a++) model[a] = '0;
    endtask

    // Apply one vector for one edge; outputs sampled on the following negedge.
    task automatic apply(input vec_t v);
        logic rdy;
        r_en = v.r_en; r_addr = v.r_addr;
        w_en = v.w_en; w_addr = v.w_addr; w_mask = v.w_mask; w_data = v.w_data;
        rdy = ready;
        @(posedge clock);
        if (rdy && v.w_en && v.w_mask && v.w_addr < 6'd33) model[v.w_addr] = v.w_data;
        @(negedge clock);
        if (v.chk) begin
            check(v.name, 16'(rdata), 16'(v.exp));
            check({v.name, "_nb"}, 16'(rdata_nb), 16'(v.exp_nb));
        end
        idle_inputs();
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 33; a++) begin
            r_en = 1'b1; r_addr = a[5:0];
            @(posedge clock);
            @(negedge clock);
            check($sformatf("%s_rd%0d", tag, a), 16'(rdata), 16'(model[a]));
            check($sformatf("%s_nb_rd%0d", tag, a), 16'(rdata_nb), 16'(model[a]));
        end
        r_en = 1'b0;
    endtask

    // Counts edges until ready rises (0 if it never does within the bound).
    // Optionally pulses flush right after edge flush_at.
    task automatic wait_ready(input int flush_at, output int n);
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clock);
            @(negedge clock);
            flush = (k == flush_at);
            if (ready) begin
                n = k;
                break;
            end
        end
        flush = 1'b0;
    endtask

    task automatic reset_edge(input string tag);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check({tag, "_ready"}, 16'(ready), 16'h0);
        check({tag, "_rdata"}, 16'(rdata), 16'h0);
        check({tag, "_rdata_nb"}, 16'(rdata_nb), 16'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;

        vecs[0]  = mk("wr5",       0,  0, 1,  5, 1, 'h2A, 0, 'h00, 'h00);
        vecs[1]  = mk("rd5",       1,  5, 0,  0, 1, 'h00, 1, 'h2A, 'h2A);
        vecs[2]  = mk("hold",      0,  0, 0,  0, 1, 'h00, 1, 'h2A, 'h2A);
        vecs[3]  = mk("rd40",      1, 40, 0,  0, 1, 'h00, 1, 'h00, 'h00);
        vecs[4]  = mk("wr40",      0,  0, 1, 40, 1, 'h3F, 1, 'h00, 'h00);
        vecs[5]  = mk("wr63_rd5",  1,  5, 1, 63, 1, 'h3F, 1, 'h2A, 'h2A);
        vecs[6]  = mk("rd40b",     1, 40, 0,  0, 1, 'h00, 1, 'h00, 'h00);
        vecs[7]  = mk("mask0",     0,  0, 1,  5, 0, 'h15, 1, 'h00, 'h00);
        vecs[8]  = mk("rd5b",      1,  5, 0,  0, 1, 'h00, 1, 'h2A, 'h2A);
        vecs[9]  = mk("wr7",       0,  0, 1,  7, 1, 'h11, 0, 'h00, 'h00);
        vecs[10] = mk("coll7",     1,  7, 1,  7, 1, 'h22, 1, 'h22, 'h11);
        vecs[11] = mk("rd7",       1,  7, 0,  0, 1, 'h00, 1, 'h22, 'h22);
        vecs[12] = mk("wr32",      0,  0, 1, 32, 1, 'h3C, 0, 'h00, 'h00);
        vecs[13] = mk("rd32",      1, 32, 0,  0, 1, 'h00, 1, 'h3C, 'h3C);
        vecs[14] = mk("rd0",       1,  0, 0,  0, 1, 'h00, 1, 'h00, 'h00);
        vecs[15] = mk("rd32_wr0",  1, 32, 1,  0, 1, 'h05, 1, 'h3C, 'h3C);
        vecs[16] = mk("rd0b",      1,  0, 0,  0, 1, 'h00, 1, 'h05, 'h05);

        clear_model();

        // Power-up reset and first initialisation sweep.
        @(negedge clock);
        reset_edge("por");
        wait_ready(0, n);
        check("init_len", 16'(n), 16'd33);
        check("init_nb_ready", 16'(ready_nb), 16'h1);
        check("init_m_ready", 16'(m_ready), 16'h1);
        sweep("post_init");

        // Byte-lane masking on the 16-bit instance.
        m_w_en = 1'b1; m_w_addr = 6'd3; m_w_data = 16'hABCD; m_w_mask = 2'b11;
        @(posedge clock); @(negedge clock);
        m_w_data = 16'h1234; m_w_mask = 2'b01;
        @(posedge clock); @(negedge clock);
        m_w_en = 1'b0; m_r_en = 1'b1; m_r_addr = 6'd3;
        @(posedge clock); @(negedge clock);
        check("mask_lo", m_rdata, 16'hAB34);
        m_w_en = 1'b1; m_w_addr = 6'd3; m_w_data = 16'h5600; m_w_mask = 2'b10;
        @(posedge clock); @(negedge clock);
        check("mask_hi_bypass", m_rdata, 16'h5634);
        m_w_en = 1'b0;
        @(posedge clock); @(negedge clock);
        check("mask_hi_rd", m_rdata, 16'h5634);
        m_r_en = 1'b0;

        // Main directed table.
        for (int i = 0; i < 17; i++) apply(vecs[i]);
        sweep("post_table");

        // Flush in READY with a concurrent write and read.
        r_en = 1'b1; r_addr = 6'd5;
        w_en = 1'b1; w_addr = 6'd9; w_data = 6'h3F;
        flush = 1'b1;
        @(posedge clock); @(negedge clock);
        check("flush_rd", 16'(rdata), 16'h2A);
        check("flush_ready", 16'(ready), 16'h0);
        // Hold user traffic through INIT; it must be ignored. Extra flush at 5.
        flush = 1'b0;
        r_addr = 6'd5; w_addr = 6'd5; w_data = 6'h3F;
        wait_ready(5, n);
        check("flush_len", 16'(n), 16'd33);
        check("flush_hold", 16'(rdata), 16'h2A);
        idle_inputs();
        clear_model();
        sweep("post_flush");

        // Reset while in READY mid-traffic.
        apply(mk("wr5_again", 0, 0, 1, 5, 1, 'h2A, 0, 'h00, 'h00));
        apply(mk("rd5_again", 1, 5, 0, 0, 1, 'h00, 1, 'h2A, 'h2A));
        r_en = 1'b1; r_addr = 6'd5; w_en = 1'b1; w_addr = 6'd6; w_data = 6'h01;
        reset_edge("rst_ready");
        idle_inputs();

        // Reset again at INIT cycle 10.
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); @(negedge clock);
        end
        check("mid_init_ready", 16'(ready), 16'h0);
        reset_edge("rst_init");
        wait_ready(0, n);
        check("reinit_len", 16'(n), 16'd33);
        clear_model();
        sweep("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sram_1r1w_sync
